// File: rtl/freq_meter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : freq_meter_pkg
// Description : Shared types and constants for the frequency meter: BCD digit
//               type, decimal nine, default sizing and an all-nines helper.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t  BCD_NINE            = 4'd9;
    localparam int          DEFAULT_DIGITS      = 4;
    localparam int unsigned DEFAULT_GATE_CYCLES = 32'd100000000;

    // Widest digit count the all-nines helper can describe.
    localparam int          MAX_DIGITS          = 16;

    // Packed BCD value with the low 'digits' nibbles at nine, rest zero.
    function automatic logic [4*MAX_DIGITS-1:0] all_nines(input int digits);
        logic [4*MAX_DIGITS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                v[4*i +: 4] = BCD_NINE;
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_meter_bcd_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bcd_counter
// Description : Multi-digit decimal accumulator. Increments on inc with a
//               ripple carry between digits, saturates at all-nines and sets
//               a sticky sat flag when an increment is lost. clear wins over
//               inc. value_inc exposes the would-be value after this cycle's
//               inc so a caller can capture it on the clearing cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter
    import freq_meter_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                inc,
    output logic [4*DIGITS-1:0] value,
    output logic                sat,
    output logic [4*DIGITS-1:0] value_inc
);

    localparam logic [4*MAX_DIGITS-1:0] C_ALL_NINES_WIDE = all_nines(DIGITS);
    localparam logic [4*DIGITS-1:0]     C_ALL_NINES      = C_ALL_NINES_WIDE[4*DIGITS-1:0];

    logic [4*DIGITS-1:0] value_q, value_d;
    logic                sat_q, sat_d;
    logic                at_max;
    logic [DIGITS-1:0]   carry;

    assign at_max   = (value_q == C_ALL_NINES);
    // No increment enters the chain once saturated, so the value holds.
    assign carry[0] = inc & ~at_max;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_t digit;
        assign digit = value_q[4*i +: 4];
        assign value_inc[4*i +: 4] = !carry[i]           ? digit :
                                     (digit == BCD_NINE) ? 4'd0  :
                                                           digit + 4'd1;
        if (i < DIGITS-1) begin : g_carry
            assign carry[i+1] = carry[i] & (digit == BCD_NINE);
        end
    end

    // Next accumulator state: clear dominates, otherwise take the increment.
    always_comb begin
        value_d = value_inc;
        sat_d   = sat_q | (inc & at_max);
        if (clear) begin
            value_d = '0;
            sat_d   = 1'b0;
        end
    end

    // Accumulator and sticky saturation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            sat_q   <= sat_d;
        end
    end

    assign value = value_q;
    assign sat   = sat_q;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : freq_meter
// Description : Counts rising edges of an asynchronous signal over a gate
//               window of GATE_CYCLES clocks and publishes the count as packed
//               BCD with a one-cycle valid pulse and an overflow flag.
//               Optional macro FREQ_METER_HOLD_EN adds a 'hold' input that
//               freezes the published result while counting continues.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int          DIGITS      = DEFAULT_DIGITS
) (
    input  logic                CLK_in,
    input  logic                RST_n,
    input  logic                sig_in,
`ifdef FREQ_METER_HOLD_EN
    input  logic                hold,
`endif
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                valid,
    output logic                overflow
);

    localparam logic [31:0]                 C_GATE_LAST      = 32'(GATE_CYCLES - 32'd1);
    localparam logic [4*MAX_DIGITS-1:0]     C_ALL_NINES_WIDE = all_nines(DIGITS);
    localparam logic [4*DIGITS-1:0]         C_ALL_NINES      = C_ALL_NINES_WIDE[4*DIGITS-1:0];

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                prev_q, prev_d;
    logic [31:0]         gate_q, gate_d;
    logic [4*DIGITS-1:0] bcd_out_q, bcd_out_d;
    logic                overflow_q, overflow_d;
    logic                valid_q, valid_d;

    logic                edge_pulse;
    logic                terminal;
    logic                hold_now;
    logic [4*DIGITS-1:0] acc_value;
    logic [4*DIGITS-1:0] acc_inc;
    logic                acc_sat;

`ifdef FREQ_METER_HOLD_EN
    assign hold_now = hold;
`else
    assign hold_now = 1'b0;
`endif

    assign edge_pulse = sync2_q & ~prev_q;
    assign terminal   = (gate_q == C_GATE_LAST);

    // The terminal cycle's edge still belongs to the closing window: it is
    // folded in through acc_inc while the accumulator clears.
    bcd_counter #(
        .DIGITS    (DIGITS)
    ) u_acc (
        .clk       (CLK_in),
        .rst_n     (RST_n),
        .clear     (terminal),
        .inc       (edge_pulse),
        .value     (acc_value),
        .sat       (acc_sat),
        .value_inc (acc_inc)
    );

    // Next-state: synchronizer shift, gate wrap and terminal-cycle capture.
    always_comb begin
        sync1_d    = sig_in;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        gate_d     = terminal ? 32'd0 : gate_q + 32'd1;
        bcd_out_d  = bcd_out_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        if (terminal && !hold_now) begin
            bcd_out_d  = acc_inc;
            overflow_d = acc_sat | (edge_pulse & (acc_value == C_ALL_NINES));
            valid_d    = 1'b1;
        end
    end

    // State registers; reset discards any partial window immediately.
    always_ff @(posedge CLK_in or negedge RST_n) begin
        if (!RST_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            gate_q     <= 32'd0;
            bcd_out_q  <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            gate_q     <= gate_d;
            bcd_out_q  <= bcd_out_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign bcd_out  = bcd_out_q;
    assign overflow = overflow_q;
    assign valid    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_freq_meter
// Description : Self-checking bench for freq_meter. Three instances:
//               A (gate 100, 4 digits), B (gate 1000, 2 digits),
//               C (gate 50, 4 digits). Expected counts come from a model that
//               counts 0->1 steps in the clock-sampled input stream, shifted
//               by the two-clock synchronizer latency, per gate window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, rst_c;
    logic        sig_a, sig_b, sig_c;
    logic [15:0] bcd_a;
    logic [7:0]  bcd_b;
    logic [15:0] bcd_c;
    logic        valid_a, valid_b, valid_c;
    logic        ovf_a, ovf_b, ovf_c;
`ifdef FREQ_METER_HOLD_EN
    logic        hold_a, hold_b, hold_c;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Generator configuration: mode 0 low, 1 high, 2 square(hi,lo), 3 random lo..hi
    int mode_a = 0, hi_a = 2, lo_a = 2, left_a = 0;
    int mode_b = 0, hi_b = 2, lo_b = 2, left_b = 0;

    // Input sampled at every rising edge since reset release
    bit samp_a[$];
    bit samp_b[$];
    bit samp_c[$];

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(100), .DIGITS(4)) u_dut_a (
        .CLK_in   (clk),
        .RST_n    (rst_a),
        .sig_in   (sig_a),
`ifdef FREQ_METER_HOLD_EN
        .hold     (hold_a),
`endif
        .bcd_out  (bcd_a),
        .valid    (valid_a),
        .overflow (ovf_a)
    );

    freq_meter #(.GATE_CYCLES(1000), .DIGITS(2)) u_dut_b (
        .CLK_in   (clk),
        .RST_n    (rst_b),
        .sig_in   (sig_b),
`ifdef FREQ_METER_HOLD_EN
        .hold     (hold_b),
`endif
        .bcd_out  (bcd_b),
        .valid    (valid_b),
        .overflow (ovf_b)
    );

    freq_meter #(.GATE_CYCLES(50), .DIGITS(4)) u_dut_c (
        .CLK_in   (clk),
        .RST_n    (rst_c),
        .sig_in   (sig_c),
`ifdef FREQ_METER_HOLD_EN
        .hold     (hold_c),
`endif
        .bcd_out  (bcd_c),
        .valid    (valid_c),
        .overflow (ovf_c)
    );

    // ---------------- helpers ----------------
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endfunction

    function automatic void gen_step(input int mode, input int hi, input int lo,
                                     inout logic lvl, inout int left);
        case (mode)
            0: begin lvl = 1'b0; left = 0; end
            1: begin lvl = 1'b1; left = 0; end
            default: begin
                if (left <= 1) begin
                    lvl  = ~lvl;
                    if (mode == 2) left = lvl ? hi : lo;
                    else           left = int'($urandom_range(hi, lo));
                end else begin
                    left = left - 1;
                end
            end
        endcase
    endfunction

    function automatic int gate_of(input int d);
        case (d) 0: return 100; 1: return 1000; default: return 50; endcase
    endfunction

    function automatic int digits_of(input int d);
        return (d == 1) ? 2 : 4;
    endfunction

    function automatic logic [15:0] bcd_of(input int d);
        case (d) 0: return bcd_a; 1: return {8'h00, bcd_b}; default: return bcd_c; endcase
    endfunction

    function automatic logic valid_of(input int d);
        case (d) 0: return valid_a; 1: return valid_b; default: return valid_c; endcase
    endfunction

    function automatic logic ovf_of(input int d);
        case (d) 0: return ovf_a; 1: return ovf_b; default: return ovf_c; endcase
    endfunction

    function automatic int qsize(input int d);
        case (d) 0: return samp_a.size(); 1: return samp_b.size(); default: return samp_c.size(); endcase
    endfunction

    // Rises of the sampled stream reach the counter two clocks later; count the
    // rises whose delayed pulse falls inside window w (samples before release are 0).
    function automatic int model_count(input int d, input int w);
        bit q[$];
        int g, n;
        bit s_prev, s_before;
        case (d) 0: q = samp_a; 1: q = samp_b; default: q = samp_c; endcase
        g = gate_of(d);
        n = 0;
        for (int k = w * g; k < (w + 1) * g; k++) begin
            s_prev   = (k >= 2) ? q[k-2] : 1'b0;
            s_before = (k >= 3) ? q[k-3] : 1'b0;
            if (s_prev && !s_before) n++;
        end
        return n;
    endfunction

    function automatic void to_bcd(input int cnt, input int digits,
                                   output logic [15:0] b, output bit ovf);
        int lim, n;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        ovf = (cnt > lim - 1);
        n   = ovf ? lim - 1 : cnt;
        b   = 16'h0000;
        for (int i = 0; i < digits; i++) begin
            b[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
    endfunction

    task automatic wait_valid(input int d, input string name, output bit got);
        got = 1'b0;
        for (int n = 0; n < 2 * gate_of(d) + 4; n++) begin
            @(negedge clk);
            if (valid_of(d) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_valid_seen"}, 32'(got), 32'd1);
    endtask

    task automatic skip_window(input int d, input string name);
        bit got;
        wait_valid(d, name, got);
        @(negedge clk);
    endtask

    task automatic expect_window(input int d, input string name, input bit use_fixed,
                                 input logic [15:0] fx_bcd, input bit fx_ovf, output int w_out);
        bit got, eo;
        int sz, cnt;
        logic [15:0] eb;
        w_out = -1;
        wait_valid(d, name, got);
        if (got) begin
            sz = qsize(d);
            chk({name, "_valid_spacing"}, 32'(sz % gate_of(d)), 32'd0);
            w_out = sz / gate_of(d) - 1;
            cnt = model_count(d, w_out);
            to_bcd(cnt, digits_of(d), eb, eo);
            chk({name, "_bcd_model"}, 32'(bcd_of(d)), 32'(eb));
            chk({name, "_ovf_model"}, 32'(ovf_of(d)), 32'(eo));
            if (use_fixed) begin
                chk({name, "_bcd_fixed"}, 32'(bcd_of(d)), 32'(fx_bcd));
                chk({name, "_ovf_fixed"}, 32'(ovf_of(d)), 32'(fx_ovf));
            end
            @(negedge clk);
            chk({name, "_valid_one_cycle"}, 32'(valid_of(d)), 32'd0);
        end
    endtask

    // ---------------- stimulus generators and samplers ----------------
    initial begin
        sig_a = 1'b0;
        forever begin
            @(negedge clk);
            gen_step(mode_a, hi_a, lo_a, sig_a, left_a);
        end
    end

    initial begin
        sig_b = 1'b0;
        forever begin
            @(negedge clk);
            gen_step(mode_b, hi_b, lo_b, sig_b, left_b);
        end
    end

    initial forever begin
        @(posedge clk);
        if (!rst_a) samp_a.delete(); else samp_a.push_back(sig_a);
    end

    initial forever begin
        @(posedge clk);
        if (!rst_b) samp_b.delete(); else samp_b.push_back(sig_b);
    end

    initial forever begin
        @(posedge clk);
        if (!rst_c) samp_c.delete(); else samp_c.push_back(sig_c);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    typedef struct {
        int          mode;
        int          hi;
        int          lo;
        logic [15:0] bcd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int  w, nvalid;
        bit  found;
        logic prev_lvl;

        tbl[0] = '{2,  2,  2, 16'h0025};
        tbl[1] = '{2,  2,  3, 16'h0020};
        tbl[2] = '{2, 10, 10, 16'h0005};
        tbl[3] = '{2,  7, 13, 16'h0005};
        tbl[4] = '{2, 50, 50, 16'h0001};
        tbl[5] = '{1,  0,  0, 16'h0000};
        tbl[6] = '{0,  0,  0, 16'h0000};
        tbl[7] = '{2,  3,  2, 16'h0020};

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; sig_c = 1'b0;
`ifdef FREQ_METER_HOLD_EN
        hold_a = 1'b0; hold_b = 1'b0; hold_c = 1'b0;
`endif
        mode_a = 2; hi_a = 5; lo_a = 5;
        repeat (30) @(negedge clk);

        chk("reset_bcd", 32'(bcd_a), 32'd0);
        chk("reset_valid", 32'(valid_a), 32'd0);
        chk("reset_ovf", 32'(ovf_a), 32'd0);

        // Release just as a high phase begins so each window holds exactly 10 rises
        found = 1'b0;
        prev_lvl = sig_a;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk); #1;
            if (sig_a && !prev_lvl) begin
                found = 1'b1;
                break;
            end
            prev_lvl = sig_a;
        end
        chk("align_found", 32'(found), 32'd1);
        rst_a = 1'b1;

        expect_window(0, "basic_w0", 1'b1, 16'h0010, 1'b0, w);
        chk("basic_first_window_index", 32'(w), 32'd0);
        expect_window(0, "basic_w1", 1'b1, 16'h0010, 1'b0, w);
        chk("basic_second_window_index", 32'(w), 32'd1);

        for (int i = 0; i < 8; i++) begin
            mode_a = tbl[i].mode; hi_a = tbl[i].hi; lo_a = tbl[i].lo;
            skip_window(0, $sformatf("tbl%0d_settle", i));
            expect_window(0, $sformatf("tbl%0d", i), 1'b1, tbl[i].bcd, 1'b0, w);
        end

        // Asynchronous reset in the middle of a window
        mode_a = 2; hi_a = 5; lo_a = 5;
        skip_window(0, "pre_reset_settle");
        expect_window(0, "pre_reset", 1'b1, 16'h0010, 1'b0, w);
        repeat (38) @(negedge clk);
        #2 rst_a = 1'b0;
        #1;
        chk("async_reset_bcd", 32'(bcd_a), 32'd0);
        chk("async_reset_valid", 32'(valid_a), 32'd0);
        chk("async_reset_ovf", 32'(ovf_a), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        expect_window(0, "post_reset", 1'b0, 16'h0000, 1'b0, w);
        chk("post_reset_first_window_index", 32'(w), 32'd0);

        // Randomized phase lengths, checked against the model
        mode_a = 3; hi_a = 12; lo_a = 2;
        for (int i = 0; i < 4; i++) begin
            expect_window(0, $sformatf("rand_a%0d", i), 1'b0, 16'h0000, 1'b0, w);
        end

`ifdef FREQ_METER_HOLD_EN
        mode_a = 2; hi_a = 5; lo_a = 5;
        skip_window(0, "hold_settle");
        expect_window(0, "hold_pre", 1'b1, 16'h0010, 1'b0, w);
        hold_a = 1'b1;
        mode_a = 2; hi_a = 2; lo_a = 3;
        nvalid = 0;
        for (int n = 0; n < 105; n++) begin
            @(negedge clk);
            if (valid_a === 1'b1) nvalid++;
        end
        chk("hold_no_valid", 32'(nvalid), 32'd0);
        chk("hold_bcd_kept", 32'(bcd_a), 32'h0010);
        chk("hold_ovf_kept", 32'(ovf_a), 32'd0);
        hold_a = 1'b0;
        expect_window(0, "hold_release", 1'b1, 16'h0020, 1'b0, w);
`else
        nvalid = 0;
`endif

        // Saturation on a 2-digit meter
        mode_b = 2; hi_b = 2; lo_b = 2;
        repeat (10) @(negedge clk);
        rst_b = 1'b1;
        expect_window(1, "sat", 1'b1, 16'h0099, 1'b1, w);
        chk("sat_first_window_index", 32'(w), 32'd0);
        mode_b = 0;
        expect_window(1, "sat_tail", 1'b0, 16'h0000, 1'b0, w);
        expect_window(1, "sat_idle", 1'b1, 16'h0000, 1'b0, w);
        mode_b = 3; hi_b = 6; lo_b = 2;
        for (int i = 0; i < 3; i++) begin
            expect_window(1, $sformatf("rand_b%0d", i), 1'b0, 16'h0000, 1'b0, w);
        end

        // Edge landing on the terminal cycle belongs to the closing window
        @(negedge clk);
        rst_c = 1'b1;
        for (int j = 1; j <= 49; j++) begin
            @(negedge clk);
            sig_c = ((j >= 9) && (j < 12)) || ((j >= 19) && (j < 22)) || (j == 47) || (j == 48);
        end
        expect_window(2, "term_edge", 1'b1, 16'h0003, 1'b0, w);
        chk("term_edge_window_index", 32'(w), 32'd0);
        expect_window(2, "term_idle", 1'b1, 16'h0000, 1'b0, w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
